alu_wb_buffer: RTL and testbench
================================

Name: alu_wb_buffer

Overview:
- Result-side counterpart of the single-cycle ALU. It accepts one ALU result per cycle from the issue/execute stage and buffers it in a small FIFO.
- It drains entries to the scoreboard writeback port under a valid/ready handshake, so the ALU can keep issuing while writeback is arbitrated away.
- It supplies back-pressure to issue and supports a pipeline flush.

Parameters:
- XLEN, 64, data width of result (32 or 64 only).
- TRANS_ID_BITS, 3, width of the scoreboard transaction id.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- FALL_THROUGH, 0, 1 = an entry presented while the buffer is empty appears on the writeback port in the same cycle.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all buffered and incoming entries.
- alu_valid_i  in  1  ALU result present this cycle.
- alu_ready_o  out  1  buffer can accept an entry this cycle.
- trans_id_i  in  TRANS_ID_BITS  id of the incoming result.
- result_i  in  XLEN  ALU result value.
- branch_res_i  in  1  ALU branch comparison outcome.
- wb_valid_o  out  1  writeback entry available.
- wb_ready_i  in  1  scoreboard accepts the writeback entry.
- wb_trans_id_o  out  TRANS_ID_BITS  id of the head entry.
- wb_result_o  out  XLEN  result of the head entry.
- wb_branch_res_o  out  1  branch outcome of the head entry.
- usage_o  out  $clog2(DEPTH)+1  current number of stored entries.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH entries {trans_id, result, branch_res}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Separate count register, width $clog2(DEPTH)+1.
- Reset (rst_ni low, asynchronous):
  - Pointers = 0, count = 0.
  - Outputs: wb_valid_o=0, alu_ready_o=1, usage_o=0.
  - Storage contents are don't-care, but wb_trans_id_o/wb_result_o/wb_branch_res_o must read 0 while empty in reset, i.e. storage entries are reset to 0.
- Handshakes:
  - push = alu_valid_i & alu_ready_o & ~flush_i.
  - pop = wb_valid_o & wb_ready_i & ~flush_i.
- Back-pressure: alu_ready_o = (count != DEPTH). It is registered-state only; there is no combinational path from wb_ready_i.
  - Full: alu_ready_o=0. An asserted alu_valid_i is ignored, no entry is written, and issue must hold the result.
- FALL_THROUGH=0:
  - wb_valid_o = (count != 0).
  - wb_* = entry at the read pointer.
  - Latency from push to wb_valid_o is 1 cycle.
- FALL_THROUGH=1, buffer empty, alu_valid_i=1:
  - wb_valid_o=1 and wb_* = the inputs, combinationally.
  - If wb_ready_i=1 in that cycle, the entry is consumed without being stored: count unchanged, pointers unchanged.
  - Otherwise it is stored normally.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - Allowed when non-full, including at count=1 (head pops while the new entry is written).
- Empty: wb_valid_o=0 (except the fall-through case); wb_ready_i is ignored.
- Pointer wrap: the pointer goes DEPTH-1 -> 0 with no bubble.
- Flush (flush_i=1):
  - Next cycle: count=0 and both pointers=0.
  - A push in the flush cycle is dropped, and no pop is reported as accepted.
  - wb_valid_o may still be high during the flush cycle, but the scoreboard must ignore it; the block guarantees no entry survives.
  - Flush takes priority over push and pop.
- Ordering: strict FIFO. trans_ids leave in the order they were accepted; no reordering or duplication.
- usage_o = count. Invariant: 0 <= count <= DEPTH.
- No combinational loop: alu_ready_o does not depend on alu_valid_i, wb_ready_i, or flush_i.

Test Plan:
- Reset mid-operation: push 3 entries, then assert rst_ni=0 asynchronously between edges -> wb_valid_o=0, usage_o=0, alu_ready_o=1 immediately, with no clock edge needed.
- Fill to full (DEPTH=4), wb_ready_i=0:
  - Push ids 0,1,2,3 with results 0x10..0x13 -> usage_o=4, alu_ready_o=0.
  - Pushing id 4 is ignored.
  - Then wb_ready_i=1 -> drains in order 0,1,2,3 with matching results.
- Steady stream with wb_ready_i=1 every cycle, FALL_THROUGH=0: push ids 0..7 on consecutive cycles -> each appears one cycle later, usage_o stays at 1, pointers wrap with no bubble.
- FALL_THROUGH=1, buffer empty:
  - alu_valid_i=1, id=5, result=0xDEAD, wb_ready_i=1 -> wb_valid_o=1, wb_trans_id_o=5 in the same cycle; usage_o stays 0.
  - With wb_ready_i=0 instead -> usage_o=1 next cycle.
- Flush with simultaneous push: 3 entries buffered, flush_i=1 with alu_valid_i=1 id=6 -> next cycle usage_o=0, wb_valid_o=0; id 6 is never output.
- Random push/pop against a reference queue model, 10k cycles with random wb_ready_i and flush (1%) -> output order and content match, and count never exceeds DEPTH.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - ALU result writeback buffer (small FIFO toward scoreboard writeback)
//
// Purpose: accepts one ALU result per cycle and queues it until the scoreboard
// writeback port accepts it. This lets issue keep going while writeback is
// arbitrated elsewhere. The block drives back-pressure to issue and supports a
// synchronous pipeline flush.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   flush_i          synchronous flush; drops buffered and incoming entries
//   alu_valid_i      ALU result present
//   alu_ready_o      buffer can accept an entry (depends on state only)
//   trans_id_i       scoreboard id of the incoming result
//   result_i         ALU result value
//   branch_res_i     ALU branch comparison outcome
//   wb_valid_o       writeback entry available
//   wb_ready_i       scoreboard accepts the writeback entry
//   wb_trans_id_o    id of the head entry
//   wb_result_o      result of the head entry
//   wb_branch_res_o  branch outcome of the head entry
//   usage_o          number of stored entries
module alu_wb_buffer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 4,
  parameter bit          FALL_THROUGH  = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [XLEN-1:0]          result_i,
  input  logic                     branch_res_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_branch_res_o,
  output logic [$clog2(DEPTH):0]   usage_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TRANS_ID_BITS-1:0] mem_id  [DEPTH];
  logic [XLEN-1:0]          mem_res [DEPTH];
  logic                     mem_br  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic empty;
  logic bypass;
  logic bypass_taken;
  logic push;
  logic pop;
  logic do_write;
  logic do_read;

  assign empty       = (count == '0);
  // Ready comes from the count register alone, so issue never sees a
  // combinational path from writeback or flush.
  assign alu_ready_o = (count != FULL_CNT);

  // Fall-through: while empty, the incoming entry is shown directly on the
  // writeback port.
  assign bypass = FALL_THROUGH & empty & alu_valid_i;

  assign wb_valid_o      = ~empty | bypass;
  assign wb_trans_id_o   = bypass ? trans_id_i   : mem_id[rd_ptr];
  assign wb_result_o     = bypass ? result_i     : mem_res[rd_ptr];
  assign wb_branch_res_o = bypass ? branch_res_i : mem_br[rd_ptr];

  assign push = alu_valid_i & alu_ready_o & ~flush_i;
  assign pop  = wb_valid_o & wb_ready_i & ~flush_i;

  // A bypassed entry that is accepted in the same cycle never touches storage.
  assign bypass_taken = bypass & wb_ready_i & ~flush_i;
  assign do_write     = push & ~bypass_taken;
  assign do_read      = pop & ~bypass_taken;

  assign usage_o = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head outputs read zero while empty after reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_id[i]  <= '0;
        mem_res[i] <= '0;
        mem_br[i]  <= 1'b0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        mem_id[wr_ptr]  <= trans_id_i;
        mem_res[wr_ptr] <= result_i;
        mem_br[wr_ptr]  <= branch_res_i;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_write, do_read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - scoreboard bench for alu_wb_buffer (instances with FALL_THROUGH 0 and 1)
module tb_alu_wb_buffer;

  localparam int XLEN  = 64;
  localparam int TIDW  = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [TIDW-1:0] id;
    logic [XLEN-1:0] res;
    logic            br;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            flush     [2];
  logic            alu_valid [2];
  logic            alu_ready [2];
  logic [TIDW-1:0] tid       [2];
  logic [XLEN-1:0] res       [2];
  logic            br        [2];
  logic            wb_valid  [2];
  logic            wb_ready  [2];
  logic [TIDW-1:0] wb_tid    [2];
  logic [XLEN-1:0] wb_res    [2];
  logic            wb_br     [2];
  logic [2:0]      usage     [2];

  alu_wb_buffer #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW), .DEPTH(DEPTH), .FALL_THROUGH(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
    .alu_valid_i(alu_valid[0]), .alu_ready_o(alu_ready[0]),
    .trans_id_i(tid[0]), .result_i(res[0]), .branch_res_i(br[0]),
    .wb_valid_o(wb_valid[0]), .wb_ready_i(wb_ready[0]),
    .wb_trans_id_o(wb_tid[0]), .wb_result_o(wb_res[0]), .wb_branch_res_o(wb_br[0]),
    .usage_o(usage[0])
  );

  alu_wb_buffer #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW), .DEPTH(DEPTH), .FALL_THROUGH(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
    .alu_valid_i(alu_valid[1]), .alu_ready_o(alu_ready[1]),
    .trans_id_i(tid[1]), .result_i(res[1]), .branch_res_i(br[1]),
    .wb_valid_o(wb_valid[1]), .wb_ready_i(wb_ready[1]),
    .wb_trans_id_o(wb_tid[1]), .wb_result_o(wb_res[1]), .wb_branch_res_o(wb_br[1]),
    .usage_o(usage[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  entry_t          exp_q [2][$];
  int              mcnt  [2];
  logic [TIDW-1:0] log_id  [$];
  logic [XLEN-1:0] log_res [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reference count and queue per instance, compared at the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   cnt;
      bit   fall, ev, push, pop;
      entry_t e;
      if (!rst_n) begin
        mcnt[d] = 0;
        exp_q[d].delete();
      end else begin
        cnt  = mcnt[d];
        fall = (d == 1) && (cnt == 0) && alu_valid[d];
        ev   = (cnt != 0) || fall;
        push = alu_valid[d] && (cnt != DEPTH) && !flush[d];
        pop  = ev && wb_ready[d] && !flush[d];
        chk($sformatf("wb_valid[%0d]", d), 64'(wb_valid[d]), 64'(ev));
        chk($sformatf("usage[%0d]", d), 64'(usage[d]), 64'(cnt));
        chk($sformatf("alu_ready[%0d]", d), 64'(alu_ready[d]), 64'(cnt != DEPTH));
        if (push) begin
          e.id = tid[d]; e.res = res[d]; e.br = br[d];
          exp_q[d].push_back(e);
        end
        if (ev && exp_q[d].size() > 0) begin
          e = exp_q[d][0];
          chk($sformatf("wb_trans_id[%0d]", d), 64'(wb_tid[d]), 64'(e.id));
          chk($sformatf("wb_result[%0d]", d), wb_res[d], e.res);
          chk($sformatf("wb_branch_res[%0d]", d), 64'(wb_br[d]), 64'(e.br));
          if (pop) begin
            void'(exp_q[d].pop_front());
            if (d == 0) begin
              log_id.push_back(wb_tid[d]);
              log_res.push_back(wb_res[d]);
            end
          end
        end
        if (flush[d]) begin
          exp_q[d].delete();
          mcnt[d] = 0;
        end else begin
          mcnt[d] = cnt + int'(push) - int'(pop);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit v, input int id, input logic [63:0] r, input bit rdy, input bit fl);
    alu_valid[d] = v;
    tid[d]       = TIDW'(id);
    res[d]       = r;
    br[d]        = id[0];
    wb_ready[d]  = rdy;
    flush[d]     = fl;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 0, 64'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    step();
    #2;
    chk("rst_wb_valid", 64'(wb_valid[0]), 64'h0);
    chk("rst_usage", 64'(usage[0]), 64'h0);
    chk("rst_alu_ready", 64'(alu_ready[0]), 64'h1);
    chk("rst_wb_result", wb_res[0], 64'h0);
    chk("rst_wb_trans_id", 64'(wb_tid[0]), 64'h0);
    step();
    rst_n = 1'b1;

    // Fill to full with writeback stalled, then drain.
    step();
    log_id.delete(); log_res.delete();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, i, 64'h10 + 64'(i), 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b1, 4, 64'h14, 1'b0, 1'b0);
    #2;
    chk("full_usage", 64'(usage[0]), 64'h4);
    chk("full_alu_ready", 64'(alu_ready[0]), 64'h0);
    step();
    drive(0, 1'b0, 0, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("fill_drain_count", 64'(log_id.size()), 64'h4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_id.size()) begin
        chk($sformatf("fill_order_id%0d", i), 64'(log_id[i]), 64'(i));
        chk($sformatf("fill_order_res%0d", i), log_res[i], 64'h10 + 64'(i));
      end
    end

    // Steady stream: one push per cycle with writeback always ready.
    log_id.delete(); log_res.delete();
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b1, k, 64'h100 + 64'(k), 1'b1, 1'b0);
      #2;
      if (k >= 1) chk($sformatf("stream_usage%0d", k), 64'(usage[0]), 64'h1);
      step();
    end
    drive(0, 1'b0, 0, 64'h0, 1'b1, 1'b0);
    step(); step();
    chk("stream_count", 64'(log_id.size()), 64'h8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_id.size()) chk($sformatf("stream_id%0d", i), 64'(log_id[i]), 64'(i % 8));
    end

    // Flush with a simultaneous push.
    log_id.delete(); log_res.delete();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1'b1, i, 64'h200 + 64'(i), 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b1, 6, 64'h600, 1'b0, 1'b1);
    step();
    drive(0, 1'b0, 0, 64'h0, 1'b1, 1'b0);
    #2;
    chk("flush_usage", 64'(usage[0]), 64'h0);
    chk("flush_wb_valid", 64'(wb_valid[0]), 64'h0);
    step(); step(); step();
    chk("flush_nothing_out", 64'(log_id.size()), 64'h0);

    // Fall-through instance.
    drive(1, 1'b1, 5, 64'hDEAD, 1'b1, 1'b0);
    #2;
    chk("ft_wb_valid", 64'(wb_valid[1]), 64'h1);
    chk("ft_wb_trans_id", 64'(wb_tid[1]), 64'h5);
    chk("ft_wb_result", wb_res[1], 64'hDEAD);
    step();
    drive(1, 1'b1, 3, 64'hBEEF, 1'b0, 1'b0);
    #2;
    chk("ft_consumed_usage", 64'(usage[1]), 64'h0);
    step();
    drive(1, 1'b0, 0, 64'h0, 1'b0, 1'b0);
    #2;
    chk("ft_stored_usage", 64'(usage[1]), 64'h1);
    chk("ft_stored_id", 64'(wb_tid[1]), 64'h3);
    step();
    drive(1, 1'b0, 0, 64'h0, 1'b1, 1'b0);
    step(); step();

    // Asynchronous reset in the middle of operation.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, i + 1, 64'h300 + 64'(i), 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b0, 0, 64'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wb_valid", 64'(wb_valid[0]), 64'h0);
    chk("async_rst_usage", 64'(usage[0]), 64'h0);
    chk("async_rst_alu_ready", 64'(alu_ready[0]), 64'h1);
    step();
    rst_n = 1'b1;
    step();

    // Random push/pop/flush against the reference queues.
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, ($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
              {$urandom, $urandom}, ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) == 0));
      end
      step();
    end
    idle_all();
    for (int i = 0; i < 8; i++) step();
    chk("rand_drain0", 64'(exp_q[0].size()), 64'h0);
    chk("rand_drain1", 64'(exp_q[1].size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
